uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_byte_handshake.sv | 49 ++++
 rtl/uart_frame_tx.sv | 136 +++++++++++++
 tb/tb_uart_frame_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame transmitter.
package uart_pkg;

  localparam int unsigned ByteWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/uart_byte_handshake.sv
// Per-byte WAIT/SEND handshake with the UART transmitter; one byte per start/continue cycle.
module uart_byte_handshake
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic last,
  input  logic uart_busy,
  input  logic uart_send_done,
  output logic uart_send,
  output logic byte_done
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StWait;
      StWait: if (!uart_busy) state_d = StSend;
      StSend: begin
        // Dropping back to WAIT between bytes guarantees a one-cycle gap on uart_send.
        if (uart_send_done) begin
          byte_done = 1'b1;
          state_d   = last ? StIdle : StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d   = StIdle;
      byte_done = 1'b0;
    end
  end

  assign uart_send = (state_q == StSend);

endmodule

// File: rtl/uart_frame_tx.sv
// Frame sequencer: captures an NBYTES payload and hands it byte-wise to a UART transmitter.
// Define UART_FRAME_CHECKSUM_EN to append an XOR checksum byte after the payload.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned NBYTES    = 5,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          send,
  input  logic [ByteWidth*NBYTES-1:0]   data,
  input  logic                          abort,
  output logic                          ready,
  output logic                          send_done,
  output logic [$clog2(NBYTES+1)-1:0]   byte_idx,
  output logic                          uart_send,
  output logic [ByteWidth-1:0]          send_data,
  input  logic                          uart_busy,
  input  logic                          uart_send_done
);

  localparam int unsigned IdxW = $clog2(NBYTES + 1);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned NumBytes = NBYTES + 1;
`else
  localparam int unsigned NumBytes = NBYTES;
`endif

  // Frame-level state: StSend covers the whole transfer; the handshake owns WAIT/SEND per byte.
  state_e                      frame_q, frame_d;
  logic [ByteWidth*NBYTES-1:0] shadow_q, shadow_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        accept;
  logic                        last;
  logic                        byte_done;
  logic [ByteWidth-1:0]        cur_byte;
  int unsigned                 sel;

  assign accept = (frame_q == StIdle) && send && !abort;
  assign last   = (idx_q == IdxW'(NumBytes - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q  <= StIdle;
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    frame_d  = frame_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    unique case (frame_q)
      StIdle: begin
        if (accept) begin
          frame_d  = StSend;
          shadow_d = data;
          idx_d    = '0;
        end
      end
      StSend: begin
        if (byte_done) begin
          if (last) frame_d = StDone;
          else      idx_d   = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        frame_d = StIdle;
        idx_d   = '0;
      end
      default: frame_d = StIdle;
    endcase
    if (abort) begin
      frame_d = StIdle;
      idx_d   = '0;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  logic [ByteWidth-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        csum_d = csum_d ^ data[ByteWidth*i +: ByteWidth];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    sel = 32'(idx_q);
    if (MSB_FIRST) sel = NBYTES - 1 - sel;
    cur_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (sel == i) cur_byte = shadow_q[ByteWidth*i +: ByteWidth];
    end
`ifdef UART_FRAME_CHECKSUM_EN
    if (idx_q == IdxW'(NBYTES)) cur_byte = csum_q;
`endif
  end

  uart_byte_handshake u_handshake (
    .clk            (clk),
    .rst            (rst),
    .start          (accept),
    .abort          (abort),
    .last           (last),
    .uart_busy      (uart_busy),
    .uart_send_done (uart_send_done),
    .uart_send      (uart_send),
    .byte_done      (byte_done)
  );

  assign ready     = (frame_q == StIdle);
  assign send_done = (frame_q == StDone) && !abort;
  assign byte_idx  = idx_q;
  assign send_data = (frame_q == StSend) ? cur_byte : '0;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: LSB-first and MSB-first instances driven in lockstep.
module tb_uart_frame_tx;

  localparam int unsigned NB = 5;
  localparam int unsigned IW = $clog2(NB + 1);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NSENT = NB + 1;
`else
  localparam int NSENT = NB;
`endif

  logic            clk = 1'b0;
  logic            rst, send, abort, uart_busy, stray_done;
  logic [8*NB-1:0] data;

  logic [1:0]          ready, send_done, uart_send, uart_send_done;
  logic [1:0][IW-1:0]  byte_idx;
  logic [1:0][7:0]     send_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    uart_frame_tx #(
      .NBYTES    (NB),
      .MSB_FIRST (g == 1)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .send           (send),
      .data           (data),
      .abort          (abort),
      .ready          (ready[g]),
      .send_done      (send_done[g]),
      .byte_idx       (byte_idx[g]),
      .uart_send      (uart_send[g]),
      .send_data      (send_data[g]),
      .uart_busy      (uart_busy),
      .uart_send_done (uart_send_done[g])
    );
  end

  // UART transmitter model and byte recorder, one lane per DUT.
  int         cnt [2];
  logic [1:0] done_r = '0;
  logic [7:0] got_q [2][$];
  int         idx_q [2][$];
  int         done_cnt [2];
  int         gap_err [2];

  assign uart_send_done = done_r | {2{stray_done}};

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        cnt[l]    <= 0;
        done_r[l] <= 1'b0;
      end else if (done_r[l]) begin
        done_r[l] <= 1'b0;
        cnt[l]    <= 0;
        if (uart_send[l]) gap_err[l] <= gap_err[l] + 1;
      end else if (uart_send[l]) begin
        if (cnt[l] == 2) begin
          done_r[l] <= 1'b1;
          cnt[l]    <= 0;
          got_q[l].push_back(send_data[l]);
          idx_q[l].push_back(int'(byte_idx[l]));
        end else begin
          cnt[l] <= cnt[l] + 1;
        end
      end else begin
        cnt[l] <= 0;
      end
      if (send_done[l]) done_cnt[l] <= done_cnt[l] + 1;
    end
  end

  // Reference: k-th byte on the wire for a given payload and byte order.
  function automatic logic [7:0] model_byte(input logic [8*NB-1:0] d, input bit msb, input int k);
    logic [7:0] x;
    int         pos;
    if (k >= int'(NB)) begin
      x = 8'h00;
      for (int i = 0; i < int'(NB); i++) x = x ^ 8'((d >> (8 * i)) & 40'hFF);
      return x;
    end
    pos = msb ? (int'(NB) - 1 - k) : k;
    return 8'((d >> (8 * pos)) & 40'hFF);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [8*NB-1:0] d, input int busy_hold, input bit rand_busy,
                           input bit mid_send);
    int b0 [2];
    int d0 [2];
    int g0 [2];
    int viol;
    bit finished;
    for (int l = 0; l < 2; l++) begin
      b0[l] = got_q[l].size();
      d0[l] = done_cnt[l];
      g0[l] = gap_err[l];
    end
    @(negedge clk);
    send      = 1'b1;
    data      = d;
    uart_busy = (busy_hold > 0);
    @(posedge clk); #1;
    check("accept_ready_low", ready, 2'b00);
    @(negedge clk);
    send = 1'b0;
    viol = 0;
    for (int i = 0; i < busy_hold; i++) begin
      if (i > 0) @(negedge clk);
      data       = 40'({$urandom(), $urandom()});
      stray_done = (i == 1);
      @(posedge clk); #1;
      if (uart_send != 2'b00) viol++;
    end
    if (busy_hold > 0) check("busy_hold_no_uart_send", viol, 0);
    finished = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      stray_done = 1'b0;
      data       = 40'({$urandom(), $urandom()});
      uart_busy  = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      send       = mid_send && (cyc == 6);
      if (done_cnt[0] != d0[0] && done_cnt[1] != d0[1]) begin
        finished = 1'b1;
        break;
      end
    end
    send      = 1'b0;
    uart_busy = 1'b0;
    check("frame_complete", finished, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    check("ready_after_frame", ready, 2'b11);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("send_done_pulses_lane%0d", l), done_cnt[l] - d0[l], 1);
      check($sformatf("byte_count_lane%0d", l), got_q[l].size() - b0[l], NSENT);
      check($sformatf("gap_lane%0d", l), gap_err[l] - g0[l], 0);
      for (int k = 0; k < NSENT; k++) begin
        if (b0[l] + k < got_q[l].size()) begin
          check($sformatf("byte%0d_lane%0d", k, l), got_q[l][b0[l]+k], model_byte(d, l == 1, k));
          check($sformatf("idx%0d_lane%0d", k, l), idx_q[l][b0[l]+k], k);
        end
      end
    end
  endtask

  // Wait (bounded) for lane 0 to start sending byte n; reports expiry as a failure.
  task automatic wait_byte(input int n, input string name);
    bit hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (uart_send[0] && byte_idx[0] == IW'(n)) begin
        hit = 1'b1;
        break;
      end
    end
    check(name, hit, 1'b1);
  endtask

  typedef struct {
    logic [8*NB-1:0] data;
    int              busy_hold;
    bit              mid_send;
    logic [7:0]      exp_first;
    logic [7:0]      exp_last;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int s0;
    int b0;
    int d0;
    int seen;

    vecs[0] = '{40'h4433221100, 0, 1'b0, 8'h00, 8'h44};
    vecs[1] = '{40'h4433221100, 20, 1'b0, 8'h00, 8'h44};
`ifdef UART_FRAME_CHECKSUM_EN
    vecs[2] = '{40'h0F0F0F0F01, 0, 1'b1, 8'h01, 8'h01};
    vecs[3] = '{40'hA55AFF0081, 3, 1'b0, 8'h81, 8'h81};
`else
    vecs[2] = '{40'h0F0F0F0F01, 0, 1'b1, 8'h01, 8'h0F};
    vecs[3] = '{40'hA55AFF0081, 3, 1'b0, 8'h81, 8'hA5};
`endif

    rst        = 1'b1;
    send       = 1'b0;
    abort      = 1'b0;
    uart_busy  = 1'b0;
    stray_done = 1'b0;
    data       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 2'b11);
    check("rst_byte_idx", byte_idx, '0);
    check("rst_uart_send", uart_send, 2'b00);
    check("rst_send_data", send_data, '0);
    check("rst_send_done", send_done, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      s0 = got_q[0].size();
      run_frame(vecs[i].data, vecs[i].busy_hold, 1'b0, vecs[i].mid_send);
      if (got_q[0].size() >= s0 + NSENT) begin
        check($sformatf("vec%0d_first", i), got_q[0][s0], vecs[i].exp_first);
        check($sformatf("vec%0d_last", i), got_q[0][s0+NSENT-1], vecs[i].exp_last);
      end
    end

    // send together with abort in IDLE, plus a stray uart_send_done: nothing starts.
    @(negedge clk);
    send       = 1'b1;
    abort      = 1'b1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    check("send_abort_idle_ready", ready, 2'b11);
    @(negedge clk);
    send       = 1'b0;
    abort      = 1'b0;
    stray_done = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (uart_send != 2'b00 || ready != 2'b11) seen++;
    end
    check("send_abort_idle_quiet", seen, 0);

    // Abort during byte 2.
    b0 = got_q[0].size();
    d0 = done_cnt[0];
    @(negedge clk);
    send = 1'b1;
    data = 40'h8877665544;
    @(negedge clk);
    send = 1'b0;
    wait_byte(2, "abort_reach_byte2");
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_uart_send", uart_send, 2'b00);
    check("abort_ready", ready, 2'b11);
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_send_done", done_cnt[0] - d0, 0);
    check("abort_bytes_before", got_q[0].size() - b0, 2);
    run_frame(40'h0123456789, 1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame.
    @(negedge clk);
    send = 1'b1;
    data = 40'hDEADBEEF42;
    @(negedge clk);
    send = 1'b0;
    wait_byte(1, "rst_reach_byte1");
    #2;
    rst = 1'b1;
    #1;
    check("midrst_uart_send", uart_send, 2'b00);
    check("midrst_ready", ready, 2'b11);
    check("midrst_byte_idx", byte_idx, '0);
    check("midrst_send_data", send_data, '0);
    check("midrst_send_done", send_done, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(40'h4433221100, 0, 1'b0, 1'b0);

    // Random payloads with random WAIT stalls.
    for (int r = 0; r < 8; r++) begin
      run_frame(40'({$urandom(), $urandom()}), int'($urandom_range(0, 4)), 1'b1, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
